alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, operand/result width (signed).
REQ-002 Parameter ALU_LAT, default 1, ALU_TOP input-to-output register latency in cycles (1..4).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  2  per-requester operation request.
REQ-006 req_ready  output  2  per-requester accept; transfer on valid&&ready.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  DATA_W each  signed operands per requester.
REQ-008 req0_fun / req1_fun  input  4  ALU_FUN code per requester.
REQ-009 rsp_valid  output  2  per-requester result valid.
REQ-010 rsp_ready  input  2  per-requester result accept.
REQ-011 rsp_data  output  DATA_W  result, shared by both requesters.
REQ-012 rsp_flag  output  1  flag accompanying rsp_data.
REQ-013 alu_a, alu_b  output  DATA_W  registered operands to ALU_TOP.
REQ-014 alu_fun  output  4  registered ALU_FUN to ALU_TOP.
REQ-015 alu_arith_out, alu_logic_out, alu_cmp_out, alu_shift_out  input  DATA_W each  ALU_TOP results.
REQ-016 alu_arith_flag, alu_logic_flag, alu_cmp_flag, alu_shift_flag  input  1 each  ALU_TOP flags.
REQ-017 busy  output  1  high in any state except IDLE.

Function
REQ-018 FSM states IDLE, WAIT, CAPT, RESP; one operation in flight at a time.
REQ-019 IDLE: if any req_valid, req_ready SHALL be 1 for the granted requester only, combinationally, else both 0; on the accepting edge alu_a/alu_b/alu_fun load the granted operands, grant index latched, go WAIT.
REQ-020 req_ready SHALL be 0 for both requesters in WAIT, CAPT, RESP.
REQ-021 WAIT holds alu_* stable for exactly ALU_LAT cycles (down-counter), then go CAPT.
REQ-022 CAPT: on its edge rsp_data/rsp_flag load the ALU output selected by alu_fun[3:2] (00 arith, 01 logic, 10 cmp, 11 shift), go RESP.
REQ-023 RESP: rsp_valid[grant]=1, other bit 0; rsp_data/rsp_flag stable until rsp_ready[grant]; on handshake go IDLE.
REQ-024 Latency: rsp_valid rises ALU_LAT+1 edges after the accepting edge; next accept possible in the cycle after the response handshake.
REQ-025 Arbitration round-robin: sole valid requester wins; both valid -> requester not granted last wins; last-grant pointer updates only on accept.
REQ-026 rsp_ready on the non-granted bit and req_valid during non-IDLE states SHALL be ignored.

Reset
REQ-027 On rst: state IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_flag=0, alu_a=alu_b=0, alu_fun=4'b1000 (compare NOP), busy=0, last-grant=1 (requester 0 wins first tie), WAIT counter 0.
REQ-028 rst asserted mid-operation SHALL abandon the in-flight operation with no response; rst dominates all other inputs.

Configuration
REQ-029 Macro ALU_ARB_FIXED_PRIO_EN defined: requester 0 always wins ties, last-grant pointer removed; undefined: round-robin per REQ-025.

Structure
REQ-030 Package alu_arb_pkg holds the FSM state enum and group localparams GRP_ARITH=2'b00, GRP_LOGIC=2'b01, GRP_CMP=2'b10, GRP_SHIFT=2'b11 and FUN_NOP=4'b1000.
REQ-031 Sub-module alu_rr_arbiter (2-way grant logic, pointer, macro handling) instantiated once.

Verification
REQ-032 Req0 only, A=-10, B=-5, fun=0000, ALU_LAT=1 -> req_ready[0] one cycle, rsp_valid[0] 2 edges later, rsp_data=-15, rsp_valid[1]=0.
REQ-033 Both valid every cycle, req0 fun=0001 (10-5), req1 fun=0100 (6&3) -> grants alternate 0,1,0,1; data 5,2 per requester.
REQ-034 Req1 fun=1010 A=5 B=1, rsp_ready[1] held low 5 cycles -> rsp_valid[1], rsp_data (cmp output) and flag stable 5 cycles; busy=1; req_ready=0 throughout.
REQ-035 rst asserted during WAIT -> next cycle IDLE, busy=0, rsp_valid=0, alu_fun=1000; next request from req1 granted if req0 idle, and req0 wins next tie.
REQ-036 With ALU_ARB_FIXED_PRIO_EN, both valid for 3 ops, fun=1100 A=4 B=1 -> all grants to requester 0, rsp_data=shift output.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_CAPT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // alu_fun[3:2] selects which ALU_TOP result group is returned
    localparam logic [1:0] GRP_ARITH = 2'b00;
    localparam logic [1:0] GRP_LOGIC = 2'b01;
    localparam logic [1:0] GRP_CMP   = 2'b10;
    localparam logic [1:0] GRP_SHIFT = 2'b11;

    localparam logic [3:0] FUN_NOP   = 4'b1000;

endpackage

// File: rtl/alu_rr_arbiter.sv
// Two-way grant logic. Round-robin by default; define ALU_ARB_FIXED_PRIO_EN
// to make requester 0 win every tie and drop the last-grant pointer.
module alu_rr_arbiter
    import alu_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_valid,
    input  logic       i_accept,
    output logic [1:0] o_gnt_oh,
    output logic       o_gnt_idx
);

    logic w_idx;

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst, i_accept};
    assign w_idx    = ~i_valid[0];
`else
    logic r_last;

    // Pointer starts at 1 so requester 0 wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (i_accept) begin
            r_last <= w_idx;
        end
    end

    assign w_idx = (i_valid == 2'b11) ? ~r_last : i_valid[1];
`endif

    assign o_gnt_idx = w_idx;
    assign o_gnt_oh  = (i_valid == 2'b00) ? 2'b00 : (w_idx ? 2'b10 : 2'b01);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one pipelined ALU_TOP between two requesters, one operation in flight.
// Tie-break policy is set by ALU_ARB_FIXED_PRIO_EN (see alu_rr_arbiter).
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ALU_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               req_valid,
    output logic [1:0]               req_ready,
    input  logic signed [DATA_W-1:0] req0_a,
    input  logic signed [DATA_W-1:0] req0_b,
    input  logic signed [DATA_W-1:0] req1_a,
    input  logic signed [DATA_W-1:0] req1_b,
    input  logic [3:0]               req0_fun,
    input  logic [3:0]               req1_fun,
    output logic [1:0]               rsp_valid,
    input  logic [1:0]               rsp_ready,
    output logic signed [DATA_W-1:0] rsp_data,
    output logic                     rsp_flag,
    output logic signed [DATA_W-1:0] alu_a,
    output logic signed [DATA_W-1:0] alu_b,
    output logic [3:0]               alu_fun,
    input  logic signed [DATA_W-1:0] alu_arith_out,
    input  logic signed [DATA_W-1:0] alu_logic_out,
    input  logic signed [DATA_W-1:0] alu_cmp_out,
    input  logic signed [DATA_W-1:0] alu_shift_out,
    input  logic                     alu_arith_flag,
    input  logic                     alu_logic_flag,
    input  logic                     alu_cmp_flag,
    input  logic                     alu_shift_flag,
    output logic                     busy
);

    localparam logic [1:0] LAT_M1 = 2'(ALU_LAT - 1);

    state_t                    r_state;
    logic [1:0]                r_cnt;
    logic                      r_gnt;
    logic signed [DATA_W-1:0]  r_alu_a, r_alu_b, r_rsp_data;
    logic [3:0]                r_alu_fun;
    logic                      r_rsp_flag;

    logic [1:0]                w_gnt_oh;
    logic                      w_gnt_idx;
    logic                      w_accept;
    logic signed [DATA_W-1:0]  w_sel_data;
    logic                      w_sel_flag;

    assign w_accept = (r_state == ST_IDLE) && (req_valid != 2'b00) && !rst;

    alu_rr_arbiter u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (req_valid),
        .i_accept  (w_accept),
        .o_gnt_oh  (w_gnt_oh),
        .o_gnt_idx (w_gnt_idx)
    );

    always_comb begin
        w_sel_data = alu_arith_out;
        w_sel_flag = alu_arith_flag;
        case (r_alu_fun[3:2])
            GRP_LOGIC: begin w_sel_data = alu_logic_out; w_sel_flag = alu_logic_flag; end
            GRP_CMP:   begin w_sel_data = alu_cmp_out;   w_sel_flag = alu_cmp_flag;   end
            GRP_SHIFT: begin w_sel_data = alu_shift_out; w_sel_flag = alu_shift_flag; end
            default:   begin w_sel_data = alu_arith_out; w_sel_flag = alu_arith_flag; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 2'd0;
            r_gnt      <= 1'b0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_fun  <= FUN_NOP;
            r_rsp_data <= '0;
            r_rsp_flag <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_alu_a   <= w_gnt_idx ? req1_a   : req0_a;
                    r_alu_b   <= w_gnt_idx ? req1_b   : req0_b;
                    r_alu_fun <= w_gnt_idx ? req1_fun : req0_fun;
                    r_gnt     <= w_gnt_idx;
                    r_cnt     <= LAT_M1;
                    r_state   <= ST_WAIT;
                end
                // Operands stay put for ALU_LAT cycles so ALU_TOP output is settled
                ST_WAIT: if (r_cnt == 2'd0) r_state <= ST_CAPT;
                         else               r_cnt   <= r_cnt - 2'd1;
                ST_CAPT: begin
                    r_rsp_data <= w_sel_data;
                    r_rsp_flag <= w_sel_flag;
                    r_state    <= ST_RESP;
                end
                ST_RESP: if (rsp_ready[r_gnt]) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == ST_IDLE && !rst) ? w_gnt_oh : 2'b00;
    assign rsp_valid = (r_state == ST_RESP) ? (r_gnt ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data  = r_rsp_data;
    assign rsp_flag  = r_rsp_flag;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_fun   = r_alu_fun;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a stand-in ALU_TOP pipeline plus a transaction-level model.
module tb_alu_arbiter;
    localparam int DW  = 16;
    localparam int LAT = 1;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
    logic signed [DW-1:0] req0_a, req0_b, req1_a, req1_b, rsp_data, alu_a, alu_b;
    logic [3:0] req0_fun, req1_fun, alu_fun;
    logic rsp_flag, busy;
    logic signed [DW-1:0] ar_o, lg_o, cm_o, sh_o;
    logic ar_f, lg_f, cm_f, sh_f;

    int n_cmp = 0;
    int n_bad = 0;
    int last_g;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(DW), .ALU_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_fun(req0_fun), .req1_fun(req1_fun),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_flag(rsp_flag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
        .alu_arith_out(ar_o), .alu_logic_out(lg_o), .alu_cmp_out(cm_o), .alu_shift_out(sh_o),
        .alu_arith_flag(ar_f), .alu_logic_flag(lg_f), .alu_cmp_flag(cm_f), .alu_shift_flag(sh_f),
        .busy(busy)
    );

    // Result of one ALU group as {flag, data}; each group gives a distinct answer
    function automatic logic [DW:0] grp_res(input logic [1:0] g, input logic signed [DW-1:0] a,
                                            input logic signed [DW-1:0] b, input logic [3:0] f);
        logic signed [DW-1:0] d;
        logic fl;
        case (g)
            2'd0: begin d = f[0] ? a - b : a + b; fl = (d == 0); end
            2'd1: begin
                case (f[1:0])
                    2'd0: d = a & b;
                    2'd1: d = a | b;
                    2'd2: d = a ^ b;
                    default: d = ~(a | b);
                endcase
                fl = ^d;
            end
            2'd2: begin d = (a < b) ? -16'sd1 : ((a == b) ? 16'sd0 : 16'sd1); fl = (a < b); end
            default: begin d = f[0] ? (a >>> b[3:0]) : (a <<< b[3:0]); fl = a[DW-1]; end
        endcase
        return {fl, d};
    endfunction

    logic [4*(DW+1)-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= {grp_res(2'd0, alu_a, alu_b, alu_fun), grp_res(2'd1, alu_a, alu_b, alu_fun),
                    grp_res(2'd2, alu_a, alu_b, alu_fun), grp_res(2'd3, alu_a, alu_b, alu_fun)};
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign {ar_f, ar_o, lg_f, lg_o, cm_f, cm_o, sh_f, sh_o} = pipe[LAT-1];

    // Winner from the arbitration rules, with last_g the requester granted most recently
    function automatic int exp_grant(input logic [1:0] v);
`ifdef ALU_ARB_FIXED_PRIO_EN
        return v[0] ? 0 : 1;
`else
        if (v == 2'b11) return (last_g == 0) ? 1 : 0;
        return v[1] ? 1 : 0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_rst();
        rst = 1'b1; req_valid = 2'b11; rsp_ready = 2'b00;
        tick(); tick();
        req_valid = 2'b00;
        rst = 1'b0;
        last_g = 1;
    endtask

    // Issues one request, waits for its response, optionally stalls, then hands it off
    task automatic do_op(input logic [1:0] v, input logic hold_valid, input int hold,
                         output logic [1:0] rdy, output int lat, output logic [1:0] rv,
                         output logic signed [DW-1:0] d, output logic fl);
        req_valid = v;
        #1 rdy = req_ready;
        tick();
        if (!hold_valid) req_valid = 2'b00;
        lat = 0;
        while (rsp_valid == 2'b00 && lat < 20) begin
            tick();
            lat++;
        end
        if (rsp_valid == 2'b00) lat = -1;
        rsp_ready = ~rsp_valid;
        repeat (hold) tick();
        rv = rsp_valid; d = rsp_data; fl = rsp_flag;
        rsp_ready = rv;
        tick();
        rsp_ready = 2'b00;
    endtask

    task automatic test_reset();
        apply_rst();
        n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL rst_ready got %b exp 00", req_ready); end
        n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL rst_rsp_valid got %b exp 00", rsp_valid); end
        n_cmp++; if (rsp_data !== 16'sd0 || rsp_flag !== 1'b0) begin n_bad++; $display("FAIL rst_rsp got %0d/%b exp 0/0", rsp_data, rsp_flag); end
        n_cmp++; if (alu_a !== 16'sd0 || alu_b !== 16'sd0) begin n_bad++; $display("FAIL rst_alu_ab got %0d/%0d exp 0/0", alu_a, alu_b); end
        n_cmp++; if (alu_fun !== 4'b1000) begin n_bad++; $display("FAIL rst_alu_fun got %b exp 1000", alu_fun); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b exp 0", busy); end
    endtask

    task automatic test_single();
        logic [1:0] rdy, rv; int lat; logic signed [DW-1:0] d; logic fl;
        req0_a = -16'sd10; req0_b = -16'sd5; req0_fun = 4'b0000;
        do_op(2'b01, 1'b0, 0, rdy, lat, rv, d, fl);
        last_g = 0;
        n_cmp++; if (rdy !== 2'b01) begin n_bad++; $display("FAIL single_ready got %b exp 01", rdy); end
        n_cmp++; if (lat !== LAT + 1) begin n_bad++; $display("FAIL single_latency got %0d exp %0d", lat, LAT + 1); end
        n_cmp++; if (rv !== 2'b01) begin n_bad++; $display("FAIL single_rsp_valid got %b exp 01", rv); end
        n_cmp++; if (d !== -16'sd15 || fl !== 1'b0) begin n_bad++; $display("FAIL single_data got %0d/%b exp -15/0", d, fl); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_idle got busy=%b exp 0", busy); end
    endtask

    task automatic test_alternate();
        logic [1:0] rdy, rv; int lat; logic signed [DW-1:0] d; logic fl;
        int eg;
        req0_a = 16'sd10; req0_b = 16'sd5; req0_fun = 4'b0001;
        req1_a = 16'sd6;  req1_b = 16'sd3; req1_fun = 4'b0100;
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            eg = 0;
`else
            eg = i % 2;
`endif
            do_op(2'b11, 1'b1, 0, rdy, lat, rv, d, fl);
            last_g = eg;
            n_cmp++; if (rdy !== (eg ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL alt_ready[%0d] got %b exp grant %0d", i, rdy, eg); end
            n_cmp++; if (rv !== (eg ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL alt_rsp_valid[%0d] got %b exp grant %0d", i, rv, eg); end
            n_cmp++; if (d !== (eg ? 16'sd2 : 16'sd5)) begin n_bad++; $display("FAIL alt_data[%0d] got %0d exp %0d", i, d, eg ? 2 : 5); end
        end
        req_valid = 2'b00;
    endtask

    task automatic test_hold();
        int w;
        req1_a = 16'sd5; req1_b = 16'sd1; req1_fun = 4'b1010;
        req_valid = 2'b10;
        #1;
        n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL hold_ready got %b exp 10", req_ready); end
        tick();
        last_g = 1;
        req_valid = 2'b11;
        w = 0;
        while (rsp_valid == 2'b00 && w < 20) begin tick(); w++; end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (rsp_valid !== 2'b10) begin n_bad++; $display("FAIL hold_valid[%0d] got %b exp 10", i, rsp_valid); end
            n_cmp++; if (rsp_data !== 16'sd1 || rsp_flag !== 1'b0) begin n_bad++; $display("FAIL hold_data[%0d] got %0d/%b exp 1/0", i, rsp_data, rsp_flag); end
            n_cmp++; if (busy !== 1'b1 || req_ready !== 2'b00) begin n_bad++; $display("FAIL hold_busy[%0d] got %b/%b exp 1/00", i, busy, req_ready); end
            rsp_ready = 2'b01;
            tick();
        end
        req_valid = 2'b00;
        rsp_ready = 2'b10;
        tick();
        rsp_ready = 2'b00;
        n_cmp++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin n_bad++; $display("FAIL hold_release got %b/%b exp 0/00", busy, rsp_valid); end
    endtask

    task automatic test_rst_mid();
        logic [1:0] rdy, rv; int lat; logic signed [DW-1:0] d; logic fl;
        req0_a = 16'sd3; req0_b = 16'sd4; req0_fun = 4'b0000;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_g = 1;
        n_cmp++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin n_bad++; $display("FAIL mid_rst_state got %b/%b exp 0/00", busy, rsp_valid); end
        n_cmp++; if (alu_fun !== 4'b1000) begin n_bad++; $display("FAIL mid_rst_fun got %b exp 1000", alu_fun); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL mid_rst_norsp[%0d] got %b exp 00", i, rsp_valid); end
        end
        req1_a = 16'sd7; req1_b = 16'sd8; req1_fun = 4'b0000;
        do_op(2'b10, 1'b0, 0, rdy, lat, rv, d, fl);
        last_g = 1;
        n_cmp++; if (rdy !== 2'b10 || d !== 16'sd15) begin n_bad++; $display("FAIL mid_rst_req1 got %b/%0d exp 10/15", rdy, d); end
        req0_a = 16'sd12; req0_b = 16'sd10; req0_fun = 4'b0110;
        do_op(2'b11, 1'b0, 0, rdy, lat, rv, d, fl);
        last_g = 0;
        n_cmp++; if (rdy !== 2'b01 || d !== 16'sd6 || fl !== 1'b0) begin n_bad++; $display("FAIL mid_rst_tie got %b/%0d/%b exp 01/6/0", rdy, d, fl); end
    endtask

`ifdef ALU_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        logic [1:0] rdy, rv; int lat; logic signed [DW-1:0] d; logic fl;
        req0_a = 16'sd4; req0_b = 16'sd1; req0_fun = 4'b1100;
        req1_a = 16'sd4; req1_b = 16'sd1; req1_fun = 4'b1100;
        for (int i = 0; i < 3; i++) begin
            do_op(2'b11, 1'b1, 0, rdy, lat, rv, d, fl);
            n_cmp++; if (rdy !== 2'b01 || d !== 16'sd8) begin n_bad++; $display("FAIL fixed[%0d] got %b/%0d exp 01/8", i, rdy, d); end
        end
        req_valid = 2'b00;
    endtask
`endif

    task automatic test_random();
        logic [1:0] rdy, rv, v, eoh; int lat, g; logic signed [DW-1:0] d; logic fl;
        logic [DW:0] er;
        apply_rst();
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                req_valid = 2'b00;
                #1;
                n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL rnd_idle_ready[%0d] got %b exp 00", n, req_ready); end
                tick();
                n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rnd_idle_busy[%0d] got %b exp 0", n, busy); end
            end
            v = 2'($urandom_range(1, 3));
            req0_a = DW'($urandom); req0_b = DW'($urandom); req0_fun = 4'($urandom);
            req1_a = DW'($urandom); req1_b = DW'($urandom); req1_fun = 4'($urandom);
            g = exp_grant(v);
            eoh = (g == 1) ? 2'b10 : 2'b01;
            er = (g == 1) ? grp_res(req1_fun[3:2], req1_a, req1_b, req1_fun)
                          : grp_res(req0_fun[3:2], req0_a, req0_b, req0_fun);
            do_op(v, 1'($urandom_range(0, 1)), $urandom_range(0, 3), rdy, lat, rv, d, fl);
            last_g = g;
            n_cmp++; if (rdy !== eoh) begin n_bad++; $display("FAIL rnd_ready[%0d] got %b exp %b", n, rdy, eoh); end
            n_cmp++; if (lat !== LAT + 1) begin n_bad++; $display("FAIL rnd_latency[%0d] got %0d exp %0d", n, lat, LAT + 1); end
            n_cmp++; if (rv !== eoh) begin n_bad++; $display("FAIL rnd_rsp_valid[%0d] got %b exp %b", n, rv, eoh); end
            n_cmp++; if ({fl, d} !== er) begin n_bad++; $display("FAIL rnd_data[%0d] got %0d/%b exp %0d/%b", n, d, fl, $signed(er[DW-1:0]), er[DW]); end
        end
        req_valid = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0; req0_fun = '0; req1_fun = '0;
        last_g = 1;
        test_reset();
        test_single();
        apply_rst();
        test_alternate();
        test_hold();
        test_rst_mid();
`ifdef ALU_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
